// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline hazard controller
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;

  localparam int REG_IDX_W     = 5;
  localparam int DEFAULT_CNT_W = 16;
  localparam int WAIT_W        = 8;

endpackage

// File: rtl/hazard_sat_counter.sv
// rtl/hazard_sat_counter.sv - saturating event counter for pipeline statistics
module hazard_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  // count up on inc, stick at all-ones instead of wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush scheduler for the 5-stage pipeline
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W    = DEFAULT_CNT_W,
  parameter int MAX_WAIT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_uses_rs1,
  input  logic                 id_uses_rs2,
  input  logic                 id_ex_mem_read,
  input  logic [REG_IDX_W-1:0] id_ex_rd,
  input  logic                 ex_branch_taken,
  input  logic                 mem_req,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic                 if_id_write,
  output logic                 if_id_flush,
  output logic                 id_ex_flush,
  output logic                 pipe_hold,
  output logic                 mem_wb_bubble,
  output logic                 halted,
  output logic [CNT_W-1:0]     stall_cycles,
  output logic [CNT_W-1:0]     flush_events
);

  localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic              load_use;
  logic              freeze;
  logic              flush_evt;
  logic              stall_inc;

  // x0 is never written, so a load targeting it cannot create a dependency
  assign load_use = id_ex_mem_read && (id_ex_rd != '0) &&
                    ((id_uses_rs1 && (id_rs1 == id_ex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == id_ex_rd)));

  // a fresh unfinished access freezes from RUN; in MEM_WAIT only mem_ready matters
  assign freeze = ((state == RUN) && mem_req && !mem_ready) ||
                  ((state == MEM_WAIT) && !mem_ready);

  // state and wait counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  // next state: enter MEM_WAIT on a pending access, trip the watchdog at MAX_WAIT
  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    case (state)
      RUN: begin
        if (mem_req && !mem_ready) begin
          wait_nxt  = WAIT_W'(1);
          state_nxt = (MAX_WAIT_C == WAIT_W'(1)) ? HALT : MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (!mem_ready) begin
          wait_nxt = wait_cnt + WAIT_W'(1);
          if (wait_nxt == MAX_WAIT_C) begin
            state_nxt = HALT;
          end
        end else begin
          wait_nxt  = '0;
          state_nxt = RUN;
        end
      end
      HALT: begin
        state_nxt = HALT;
      end
      default: begin
        state_nxt = RUN;
        wait_nxt  = '0;
      end
    endcase
  end

  // control outputs: freeze beats branch redirect, which beats load-use bubble
  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    pipe_hold     = 1'b0;
    mem_wb_bubble = 1'b0;
    halted        = 1'b0;
    flush_evt     = 1'b0;
    if (rst) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
      mem_wb_bubble = 1'b1;
    end else if (state == HALT) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      pipe_hold     = 1'b1;
      mem_wb_bubble = 1'b1;
      halted        = 1'b1;
    end else if (freeze) begin
      // EX is frozen, so a taken branch there is re-presented after release
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      pipe_hold     = 1'b1;
      mem_wb_bubble = 1'b1;
    end else if (ex_branch_taken) begin
      // the flush discards the dependent instruction, so no load-use stall
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
      flush_evt     = 1'b1;
    end else if (load_use) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_flush   = 1'b1;
    end
  end

  assign stall_inc = !rst && (state != HALT) && !pc_write;

  hazard_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (stall_cycles)
  );

  hazard_sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_evt),
    .count (flush_events)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W    = 2;
  localparam int MAX_WAIT = 4;

  // control vector order: pc_write, if_id_write, if_id_flush, id_ex_flush,
  // pipe_hold, mem_wb_bubble, halted
  localparam logic [6:0] C_RST  = 7'b0011010;
  localparam logic [6:0] C_DEF  = 7'b1100000;
  localparam logic [6:0] C_LU   = 7'b0001000;
  localparam logic [6:0] C_BR   = 7'b1111000;
  localparam logic [6:0] C_FRZ  = 7'b0000110;
  localparam logic [6:0] C_HALT = 7'b0000111;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       id_rs1, id_rs2, id_ex_rd;
  logic             id_uses_rs1, id_uses_rs2, id_ex_mem_read;
  logic             ex_branch_taken, mem_req, mem_ready;
  logic             pc_write, if_id_write, if_id_flush, id_ex_flush;
  logic             pipe_hold, mem_wb_bubble, halted;
  logic [CNT_W-1:0] stall_cycles, flush_events;
  logic [6:0]       ctl;

  int vectors     = 0;
  int miscompares = 0;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_uses_rs1     (id_uses_rs1),
    .id_uses_rs2     (id_uses_rs2),
    .id_ex_mem_read  (id_ex_mem_read),
    .id_ex_rd        (id_ex_rd),
    .ex_branch_taken (ex_branch_taken),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .if_id_flush     (if_id_flush),
    .id_ex_flush     (id_ex_flush),
    .pipe_hold       (pipe_hold),
    .mem_wb_bubble   (mem_wb_bubble),
    .halted          (halted),
    .stall_cycles    (stall_cycles),
    .flush_events    (flush_events)
  );

  always #5 clk = ~clk;

  assign ctl = {pc_write, if_id_write, if_id_flush, id_ex_flush,
                pipe_hold, mem_wb_bubble, halted};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    id_rs1 = 0; id_rs2 = 0; id_ex_rd = 0;
    id_uses_rs1 = 0; id_uses_rs2 = 0; id_ex_mem_read = 0;
    ex_branch_taken = 0; mem_req = 0; mem_ready = 0;
  endtask

  task automatic set_lu();
    id_ex_mem_read = 1; id_ex_rd = 5; id_uses_rs1 = 1; id_rs1 = 5;
  endtask

  task automatic rst_pulse();
    rst = 1; clear_in();
    #1 chk("rst_ctl", 32'(ctl), 32'(C_RST));
    cyc();
    rst = 0;
    chk("rst_stall", 32'(stall_cycles), 0);
    chk("rst_flush", 32'(flush_events), 0);
    #1 chk("rst_exit_ctl", 32'(ctl), 32'(C_DEF));
  endtask

  initial begin
    rst = 1; clear_in();
    #1 chk("reset_ctl", 32'(ctl), 32'(C_RST));
    cyc();
    chk("reset_stall", 32'(stall_cycles), 0);
    chk("reset_flush", 32'(flush_events), 0);
    rst = 0;
    #1 chk("idle_ctl", 32'(ctl), 32'(C_DEF));

    // load-use on rs1: one-cycle bubble
    cyc(); set_lu();
    #1 chk("lu_ctl", 32'(ctl), 32'(C_LU));
    cyc(); clear_in();
    chk("lu_stall", 32'(stall_cycles), 1);
    #1 chk("lu_after_ctl", 32'(ctl), 32'(C_DEF));

    // matching rs2 but not read: no stall
    cyc(); id_ex_mem_read = 1; id_ex_rd = 5; id_rs2 = 5; id_uses_rs1 = 1; id_rs1 = 3;
    #1 chk("rs2_unused_ctl", 32'(ctl), 32'(C_DEF));

    // load to x0 never stalls
    cyc(); clear_in(); id_ex_mem_read = 1; id_uses_rs1 = 1;
    #1 chk("x0_ctl", 32'(ctl), 32'(C_DEF));
    cyc(); clear_in();
    chk("x0_stall", 32'(stall_cycles), 1);

    // branch wins over load-use (via rs2)
    id_ex_mem_read = 1; id_ex_rd = 7; id_uses_rs2 = 1; id_rs2 = 7; ex_branch_taken = 1;
    #1 chk("br_lu_ctl", 32'(ctl), 32'(C_BR));
    cyc(); clear_in();
    chk("br_lu_flush", 32'(flush_events), 1);
    chk("br_lu_stall", 32'(stall_cycles), 1);
    #1 chk("br_after_ctl", 32'(ctl), 32'(C_DEF));

    rst_pulse();

    // three wait cycles, branch held throughout, release on the fourth
    cyc(); mem_req = 1; mem_ready = 0; ex_branch_taken = 1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("wait_ctl", 32'(ctl), 32'(C_FRZ));
      cyc();
    end
    chk("wait_stall", 32'(stall_cycles), 3);
    chk("wait_noflush", 32'(flush_events), 0);
    mem_ready = 1;
    #1 chk("release_ctl", 32'(ctl), 32'(C_BR));
    cyc(); clear_in();
    chk("release_flush", 32'(flush_events), 1);
    chk("release_stall", 32'(stall_cycles), 3);
    #1 chk("release_after_ctl", 32'(ctl), 32'(C_DEF));

    rst_pulse();

    // watchdog: halts after the MAX_WAIT-th wait cycle
    cyc(); mem_req = 1; mem_ready = 0;
    for (int i = 0; i < MAX_WAIT; i++) begin
      #1 chk("wd_wait_ctl", 32'(ctl), 32'(C_FRZ));
      cyc();
    end
    chk("wd_halt_ctl", 32'(ctl), 32'(C_HALT));
    mem_ready = 1; ex_branch_taken = 1;
    #1 chk("wd_sticky_ctl", 32'(ctl), 32'(C_HALT));
    cyc();
    chk("wd_flush_frozen", 32'(flush_events), 0);
    chk("wd_stall", 32'(stall_cycles), 3);
    chk("wd_still_halt", 32'(ctl), 32'(C_HALT));

    rst_pulse();

    // saturation: five consecutive load-use stalls on a 2-bit counter
    cyc(); set_lu();
    for (int i = 0; i < 5; i++) begin
      #1 chk("sat_ctl", 32'(ctl), 32'(C_LU));
      cyc();
      chk("sat_stall", 32'(stall_cycles), (i + 1 > 3) ? 3 : i + 1);
    end
    clear_in();
    #1 chk("sat_after_ctl", 32'(ctl), 32'(C_DEF));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush scheduler for the 5-stage RISC-V pipeline. It sits beside the forwarding unit and decides every cycle whether each pipeline register advances, holds, or is bubbled. It covers load-use hazards, EX-stage branch redirects, and multi-cycle data-memory waits with a timeout watchdog. It also keeps saturating stall and flush counters for performance debug.

Parameters:
CNT_W, 16, width of the stall_cycles and flush_events counters
MAX_WAIT, 64, number of consecutive data-memory wait cycles before a hard halt (range 1..255)

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-high reset
id_rs1  in  5  rs1 of the instruction in ID
id_rs2  in  5  rs2 of the instruction in ID
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
id_ex_mem_read  in  1  instruction in EX is a load
id_ex_rd  in  5  rd of the instruction in EX
ex_branch_taken  in  1  EX resolved a taken branch or jump
mem_req  in  1  MEM stage has an active data-memory access
mem_ready  in  1  data memory completes the access this cycle
pc_write  out  1  PC may update
if_id_write  out  1  IF/ID register may load
if_id_flush  out  1  IF/ID loads a NOP
id_ex_flush  out  1  ID/EX loads a NOP
pipe_hold  out  1  ID/EX and EX/MEM hold their contents
mem_wb_bubble  out  1  MEM/WB loads a NOP
halted  out  1  watchdog tripped; sticky until rst
stall_cycles  out  CNT_W  saturating count of cycles with pc_write=0 (HALT excluded)
flush_events  out  CNT_W  saturating count of taken redirects

Behaviour:
- States: RUN, MEM_WAIT, HALT. Control outputs are combinational from state and inputs; state, wait counter and stat counters are registered.
- Output values while rst=1: pc_write=0, if_id_write=0, if_id_flush=1, id_ex_flush=1, pipe_hold=0, mem_wb_bubble=1, halted=0.
- On reset: state=RUN, wait counter=0, stall_cycles=0, flush_events=0. Reset mid-wait or in HALT returns to RUN the next cycle.
- Default outputs in RUN with no hazard: pc_write=1, if_id_write=1, every flush/hold/bubble output 0.
- Load-use detection: load_use = id_ex_mem_read and id_ex_rd!=0 and ((id_uses_rs1 and id_rs1==id_ex_rd) or (id_uses_rs2 and id_rs2==id_ex_rd)).
- RUN priority, highest first:
  1. mem_req and not mem_ready: freeze. pc_write=0, if_id_write=0, pipe_hold=1, mem_wb_bubble=1. No flush is issued; a concurrent ex_branch_taken is ignored because EX is frozen and re-presents it. Next state MEM_WAIT, wait counter=1.
  2. ex_branch_taken: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_flush=1. load_use is ignored. flush_events increments.
  3. load_use: pc_write=0, if_id_write=0, id_ex_flush=1. Exactly a 1-cycle bubble, because the load advances to MEM next cycle.
- MEM_WAIT:
  - mem_ready=0: same freeze outputs as RUN case 1; wait counter increments. When the counter reaches MAX_WAIT, next state is HALT.
  - mem_ready=1: the pipeline releases that same cycle. Outputs are evaluated exactly as RUN priorities 2 and 3 (priority 1 is not re-checked). Next state RUN, wait counter cleared.
- HALT: pc_write=0, if_id_write=0, pipe_hold=1, mem_wb_bubble=1, halted=1. Counters freeze. Exit only via rst.
- Counters saturate at all-ones, with no wrap. stall_cycles increments in any non-reset, non-HALT cycle where pc_write=0.
- A load with id_ex_rd=0 never stalls. A branch flush and a load-use in the same cycle yield exactly one redirect and no extra stall.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - state encoding: RUN=2'd0, MEM_WAIT=2'd1, HALT=2'd2
  - REG_IDX_W=5
  - default CNT_W
- Sub-module hazard_sat_counter (params W; inputs clk, rst, inc; output count) is instantiated twice, for the two statistics counters.

Test Plan:
- Load-use: lw x5 in EX (id_ex_mem_read=1, id_ex_rd=5), ID add uses rs1=5 -> one cycle with pc_write=0, if_id_write=0, id_ex_flush=1; stall_cycles=1; next cycle all defaults.
- x0 load: id_ex_rd=0, id_rs1=0 -> no stall; stall_cycles stays 0.
- Branch + load-use same cycle: ex_branch_taken=1 with load_use true -> if_id_flush=1, id_ex_flush=1, pc_write=1; flush_events=1; stall_cycles=0.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then 1 -> pipe_hold=1 and mem_wb_bubble=1 for 3 cycles, release on cycle 4; stall_cycles=3; a branch_taken held through the wait flushes only on the release cycle.
- Watchdog: MAX_WAIT=4, mem_ready held 0 -> halted=1 after the 4th wait cycle and stays 1; pulsing rst one cycle -> RUN, counters 0, halted=0.
- Saturation: CNT_W=2, 5 load-use stalls -> stall_cycles=3.
